// File: rtl/broken_mon_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : broken_mon_pkg                                            |
// | Purpose  : Shared types and constants for broken_output_monitor:     |
// |            the run-tracking state enum and the read-select codes.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package broken_mon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      OVER = 2'd2
   } mon_state_t;

   localparam logic [1:0] SEL_EDGE = 2'd0;
   localparam logic [1:0] SEL_OVR  = 2'd1;
   localparam logic [1:0] SEL_MAX  = 2'd2;
   localparam logic [1:0] SEL_RUN  = 2'd3;

endpackage
`default_nettype wire

// File: rtl/broken_output_monitor_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sat_counter                                               |
// | Purpose  : Saturating up-counter with synchronous clear and load-1.  |
// | Ports    : clk_broken - clock (rising edge)                          |
// |            rst_n      - asynchronous active-low reset                |
// |            clr        - synchronous clear to 0 (highest priority)    |
// |            load1      - synchronous load of 1                        |
// |            inc        - increment, holds at all-ones                 |
// |            q          - counter value                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_broken,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         inc,
   input  logic         load1,
   output logic [W-1:0] q
);

   always_ff @(posedge clk_broken or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (load1) begin
         q <= W'(1);
      end else if (inc && (q != {W{1'b1}})) begin
         q <= q + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/broken_output_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : broken_output_monitor                                     |
// | Purpose  : Observes a level signal, counts rising events, measures   |
// |            high-run lengths, flags runs exceeding a programmable     |
// |            limit and exposes statistics through a 1-cycle read port. |
// | Ports    : clk_broken   - clock (rising edge)                        |
// |            rst_n        - asynchronous active-low reset              |
// |            mon_in       - monitored level                            |
// |            clear        - synchronous clear of statistics and FSM    |
// |            run_limit    - max legal run length, 0 disables checking  |
// |            rd_req/rd_sel- read strobe and field select               |
// |            rd_ack/rd_data - read response, 1 cycle after rd_req      |
// |            over_run_irq - one-cycle pulse per over-long run          |
// |            busy         - high while a run is in progress            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module broken_output_monitor
   import broken_mon_pkg::*;
#(
   parameter int CNT_W = 16,
   parameter int RUN_W = 8
) (
   input  logic             clk_broken,
   input  logic             rst_n,
   input  logic             mon_in,
   input  logic             clear,
   input  logic [RUN_W-1:0] run_limit,
   input  logic             rd_req,
   input  logic [1:0]       rd_sel,
   output logic             rd_ack,
   output logic [CNT_W-1:0] rd_data,
   output logic             over_run_irq,
   output logic             busy
);

   mon_state_t       state;
   logic             mon_q;
   logic [RUN_W-1:0] max_run;
   logic [CNT_W-1:0] edge_count;
   logic [CNT_W-1:0] overrun_count;
   logic [RUN_W-1:0] run_len;

   logic             run_start;
   logic             run_inc;
   logic             over_hit;
   logic [RUN_W-1:0] run_next;
   logic [CNT_W-1:0] rd_mux;

   // A run only starts on a low-to-high transition of the sampled level.
   // mon_q tracks the previous sample even across clear, so a level that is
   // already high when clear is applied is not counted until it drops.
   assign run_start = (state == IDLE) && mon_in && !mon_q;
   assign run_inc   = (state != IDLE) && mon_in;

   // Run length as it will be after this edge, for the overrun compare.
   assign run_next  = (run_len == {RUN_W{1'b1}}) ? run_len : run_len + 1'b1;
   assign over_hit  = (state == HIGH) && mon_in && (run_limit != '0) &&
                      (run_next > run_limit);

   assign busy = (state != IDLE);

   sat_counter #(.W(CNT_W)) u_edge_cnt (
      .clk_broken (clk_broken),
      .rst_n      (rst_n),
      .clr        (clear),
      .inc        (run_start),
      .load1      (1'b0),
      .q          (edge_count)
   );

   sat_counter #(.W(CNT_W)) u_ovr_cnt (
      .clk_broken (clk_broken),
      .rst_n      (rst_n),
      .clr        (clear),
      .inc        (over_hit),
      .load1      (1'b0),
      .q          (overrun_count)
   );

   sat_counter #(.W(RUN_W)) u_run_cnt (
      .clk_broken (clk_broken),
      .rst_n      (rst_n),
      .clr        (clear),
      .inc        (run_inc),
      .load1      (run_start),
      .q          (run_len)
   );

   // Read mux sees pre-update values; narrower fields are zero-extended.
   always_comb begin
      rd_mux = '0;
      case (rd_sel)
         SEL_EDGE: rd_mux = edge_count;
         SEL_OVR:  rd_mux = overrun_count;
         SEL_MAX:  rd_mux = CNT_W'(max_run);
         SEL_RUN:  rd_mux = CNT_W'(run_len);
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk_broken or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         mon_q        <= 1'b0;
         max_run      <= '0;
         over_run_irq <= 1'b0;
         rd_ack       <= 1'b0;
         rd_data      <= '0;
      end else begin
         rd_ack       <= rd_req;
         if (rd_req) begin
            rd_data <= rd_mux;
         end
         over_run_irq <= 1'b0;
         mon_q        <= mon_in;

         if (clear) begin
            state   <= IDLE;
            max_run <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (run_start) begin
                     state <= HIGH;
                  end
               end
               HIGH: begin
                  if (!mon_in) begin
                     state <= IDLE;
                     if (run_len > max_run) max_run <= run_len;
                  end else if (over_hit) begin
                     state        <= OVER;
                     over_run_irq <= 1'b1;
                  end
               end
               OVER: begin
                  if (!mon_in) begin
                     state <= IDLE;
                     if (run_len > max_run) max_run <= run_len;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire
